aes_round_sequencer: RTL and testbench

Iterative AES encryption controller that sequences the shared `one_round` / `final_round` datapath: accepts one 128-bit plaintext block, applies the initial AddRoundKey, then drives `NR-1` full rounds and one final round at two clocks per round. Round keys are fetched by index from an external round-key store. Sits between the host-facing block stream and the round datapath, with valid/ready handshakes on both stream sides.

---
 rtl/aes_round_sequencer_if.sv | 33 +++
 rtl/aes_round_sequencer.sv | 125 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_sequencer_if.sv
// Block stream, round-key store and round-datapath signals of the AES
// round sequencer; slave is the sequencer, master is its environment.
interface aes_round_sequencer_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   key_idx;
   logic [127:0] key_in;
   logic         rnd_en;
   logic         fin_en;
   logic [127:0] rnd_state;
   logic [127:0] rnd_key;
   logic [127:0] rnd_result;
   logic [127:0] fin_result;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic [31:0]  blk_count;

   modport master (
      output in_valid, in_data, key_in,
      output rnd_result, fin_result, out_ready,
      input  in_ready, key_idx, rnd_en, fin_en,
      input  rnd_state, rnd_key, out_valid, out_data, blk_count
   );

   modport slave (
      input  in_valid, in_data, key_in,
      input  rnd_result, fin_result, out_ready,
      output in_ready, key_idx, rnd_en, fin_en,
      output rnd_state, rnd_key, out_valid, out_data, blk_count
   );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round sequencer: AddRoundKey, NR-1 rounds, final round.
// Define AES_SEQ_PERF_EN to build the block and busy counters.
module aes_round_sequencer #(
   parameter int NR = 10
) (
   input logic                  clk,
   input logic                  rst,
   aes_round_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_NR   = 4'(NR);
   localparam logic [3:0] LP_LAST = 4'(NR - 1);

   state_t       r_state;
   logic [3:0]   r_rnd;
   logic         r_phase;
   logic [127:0] r_state_reg;
   logic         r_in_ready;
   logic         r_out_valid;
   logic         r_rnd_en;
   logic         r_fin_en;
   logic [3:0]   r_key_idx;
   logic         w_accept;
   logic         w_release;

   assign w_accept  = r_in_ready & bus.in_valid;
   assign w_release = r_out_valid & bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rnd       <= 4'd0;
         r_phase     <= 1'b0;
         r_state_reg <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_rnd_en    <= 1'b0;
         r_fin_en    <= 1'b0;
         r_key_idx   <= 4'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state_reg <= bus.in_data ^ bus.key_in;
                  r_rnd       <= 4'd1;
                  r_phase     <= 1'b0;
                  r_in_ready  <= 1'b0;
                  r_rnd_en    <= 1'b1;
                  r_key_idx   <= 4'd1;
                  r_state     <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_phase <= ~r_phase;
               if (r_phase) begin
                  r_rnd <= r_rnd + 4'd1;
                  if (r_rnd == LP_LAST) begin
                     r_rnd_en  <= 1'b0;
                     r_fin_en  <= 1'b1;
                     r_key_idx <= LP_NR;
                     r_state   <= S_FINAL;
                  end else begin
                     r_key_idx <= r_rnd + 4'd1;
                  end
               end
            end
            S_FINAL: begin
               r_phase <= ~r_phase;
               if (r_phase) begin
                  r_fin_en    <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (w_release) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_key_idx   <= 4'd0;
                  r_rnd       <= 4'd0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Later rounds chain from the datapath, which holds between updates.
   assign bus.rnd_state = (r_rnd == 4'd1) ? r_state_reg : bus.rnd_result;
   assign bus.rnd_key   = bus.key_in;
   assign bus.key_idx   = r_key_idx;
   assign bus.rnd_en    = r_rnd_en;
   assign bus.fin_en    = r_fin_en;
   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = bus.fin_result;

`ifdef AES_SEQ_PERF_EN
   logic [31:0] r_blk_count;
   logic [31:0] r_busy_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blk_count  <= '0;
         r_busy_count <= '0;
      end else begin
         if (w_release)
            r_blk_count <= r_blk_count + 32'd1;
         if (r_state != S_IDLE)
            r_busy_count <= r_busy_count + 32'd1;
      end
   end

   assign bus.blk_count = r_blk_count;
`else
   assign bus.blk_count = '0;
`endif
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer with a behavioural AES model,
// key stores and round datapath models for NR=10 and NR=14 instances.
`timescale 1ns/1ps
module tb_aes_round_sequencer;
   localparam int NR10 = 10;
   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_round_sequencer_if b10 ();
   aes_round_sequencer_if b14 ();
   aes_round_sequencer #(.NR(10)) dut10 (.clk(clk), .rst(rst), .bus(b10));
   aes_round_sequencer #(.NR(14)) dut14 (.clk(clk), .rst(rst), .bus(b14));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0]   sb [256];
   logic [127:0] ks10 [16];
   logic [127:0] ks14 [16];
   assign b10.key_in = ks10[b10.key_idx];
   assign b14.key_in = ks14[b14.key_idx];

   function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", nm, act, want);
      end
   endfunction

   function automatic void tmo(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired before the DUT responded", nm);
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box from the GF(2^8) inverse followed by the affine map
   task automatic build_sbox();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] inv, a, s;
         inv = 8'h00;
         for (int u = 1; u < 256; u++)
            if (gm(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
         a = inv;
         s = inv;
         for (int n = 0; n < 4; n++) begin
            a = {a[6:0], a[7]};
            s ^= a;
         end
         sb[v] = s ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input bit last);
      logic [7:0] b [16];
      logic [7:0] t [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         logic [7:0] a0, a1, a2, a3;
         a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
         if (!last) begin
            t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
            t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
            t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
            t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
      return o ^ k;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] key, input int nr, output logic [127:0] rk [16]);
      logic [31:0] w [64];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk;
      nk = nr - 6;
      rc = 8'h01;
      for (int i = 0; i < 64; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = subw(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [127:0] rk [16], input int nr);
      logic [127:0] s;
      s = pt ^ rk[0];
      for (int r = 1; r <= nr; r++) s = aes_rnd(s, rk[r], r == nr);
      return s;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Round datapath models: latch a result at the end of the second enabled cycle
   logic ph10, fph10, ph14, fph14;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph10 <= 1'b0; fph10 <= 1'b0;
         b10.rnd_result <= '0; b10.fin_result <= '0;
      end else begin
         ph10  <= b10.rnd_en ? ~ph10 : 1'b0;
         fph10 <= b10.fin_en ? ~fph10 : 1'b0;
         if (b10.rnd_en && ph10) b10.rnd_result <= aes_rnd(b10.rnd_state, b10.rnd_key, 1'b0);
         if (b10.fin_en && fph10) b10.fin_result <= aes_rnd(b10.rnd_result, b10.rnd_key, 1'b1);
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph14 <= 1'b0; fph14 <= 1'b0;
         b14.rnd_result <= '0; b14.fin_result <= '0;
      end else begin
         ph14  <= b14.rnd_en ? ~ph14 : 1'b0;
         fph14 <= b14.fin_en ? ~fph14 : 1'b0;
         if (b14.rnd_en && ph14) b14.rnd_result <= aes_rnd(b14.rnd_state, b14.rnd_key, 1'b0);
         if (b14.fin_en && fph14) b14.fin_result <= aes_rnd(b14.rnd_result, b14.rnd_key, 1'b1);
      end
   end

   // Scoreboard monitor for the NR=10 instance
   logic [127:0] exp_q [$];
   logic [127:0] held;
   int acc10, k10, hs_cnt;
   bit busy10, done10, seq_err, stall_err, hs_prev;
   always @(negedge clk) begin
      if (rst) begin
         busy10 = 0; done10 = 0; hs_prev = 0; hs_cnt = 0;
         exp_q.delete();
      end else begin
         if (hs_prev) begin
            chk("release_valid", b10.out_valid, 0);
            chk("release_ready", b10.in_ready, 1);
         end
         hs_prev = 0;
         if (busy10) begin
            k10 = cyc - acc10;
            if (k10 < 2*NR10) begin
               if (b10.key_idx != 4'(k10/2 + 1) || b10.rnd_en != (k10 < 2*NR10-2) ||
                   b10.fin_en != (k10 >= 2*NR10-2) || b10.in_ready || b10.out_valid)
                  seq_err = 1;
            end else begin
               chk("keyseq", seq_err, 0);
               chk("latency", b10.out_valid, 1);
               held = b10.out_data; stall_err = 0; busy10 = 0; done10 = 1;
            end
         end
         if (done10) begin
            if (b10.out_data !== held || !b10.out_valid || b10.in_ready || b10.rnd_en || b10.fin_en)
               stall_err = 1;
            if (b10.out_valid && b10.out_ready) begin
               chk("hold", stall_err, 0);
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL extra_block: got %h required no block", b10.out_data);
               end else begin
                  chk("cipher", b10.out_data, exp_q.pop_front());
               end
               hs_prev = 1; done10 = 0; hs_cnt++;
            end
         end
         if (b10.in_valid && b10.in_ready) begin
            acc10 = cyc + 1; busy10 = 1;
            seq_err = (b10.key_idx != 4'd0);
         end
      end
   end

   // Scoreboard monitor for the NR=14 instance
   logic [127:0] q14 [$];
   int acc14 = -1;
   always @(negedge clk) begin
      if (!rst) begin
         if (b14.in_valid && b14.in_ready) acc14 = cyc + 1;
         if (b14.out_valid && acc14 >= 0) begin
            chk("latency14", 128'(cyc - acc14), 128'(28));
            acc14 = -1;
         end
         if (b14.out_valid && b14.out_ready && q14.size() != 0)
            chk("cipher14", b14.out_data, q14.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, b10.in_ready, 1);
      chk({tag, "_out_valid"}, b10.out_valid, 0);
      chk({tag, "_rnd_en"}, b10.rnd_en, 0);
      chk({tag, "_fin_en"}, b10.fin_en, 0);
      chk({tag, "_key_idx"}, b10.key_idx, 0);
      chk({tag, "_blk_count"}, b10.blk_count, 0);
   endtask

   task automatic send10(input logic [127:0] pt, input logic [255:0] key, input logic [127:0] want);
      int n = 0;
      while (!b10.in_ready && n < 100) begin tick(); n++; end
      if (n >= 100) tmo("in_ready");
      expand(key, 10, ks10);
      exp_q.push_back(want);
      b10.in_data = pt;
      b10.in_valid = 1'b1;
      tick();
      b10.in_valid = 1'b0;
      b10.in_data = rnd128();
   endtask

   task automatic drain(input bit rand_ready);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         b10.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick(); n++;
      end
      if (exp_q.size() != 0) tmo("drain");
      b10.out_ready = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] pt, want;
      logic [127:0] rk [16];
      logic [255:0] key;
      int a [4];
      int n;
      b10.in_valid = 0; b10.in_data = '0; b10.out_ready = 1;
      b14.in_valid = 0; b14.in_data = '0; b14.out_ready = 1;
      build_sbox();
      for (int i = 0; i < 16; i++) begin ks10[i] = '0; ks14[i] = '0; end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset("reset");
      tick();

      send10(PT, K1, C1);
      drain(1'b0);

      b10.out_ready = 1'b0;
      send10(PT, K1, C1);
      n = 0;
      while (!b10.out_valid && n < 100) begin tick(); n++; end
      if (n >= 100) tmo("out_valid");
      repeat (50) tick();
      drain(1'b0);

      expand(K1, 10, ks10);
      expand(K1, 10, rk);
      b10.out_ready = 1'b1;
      b10.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pt = rnd128();
         b10.in_data = pt;
         exp_q.push_back(ref_enc(pt, rk, 10));
         n = 0;
         while (!b10.in_ready && n < 100) begin tick(); n++; end
         if (n >= 100) tmo("b2b_accept");
         a[i] = cyc + 1;
         tick();
      end
      b10.in_valid = 1'b0;
      for (int i = 1; i < 4; i++) chk("b2b_spacing", 128'(a[i] - a[i-1]), 128'(2*NR10 + 2));
      drain(1'b0);
      chk("blk_count_b2b", b10.blk_count, PERF ? 128'(hs_cnt) : 128'(0));

      for (int i = 0; i < 16; i++) begin
         key = {rnd128(), 128'h0};
         pt = rnd128();
         expand(key, 10, rk);
         want = ref_enc(pt, rk, 10);
         repeat ($urandom_range(0, 3)) tick();
         send10(pt, key, want);
         drain(1'b1);
      end

      send10(PT, K1, C1);
      repeat (9) tick();
      #2 rst = 1'b1;
      #1 chk_reset("async_reset");
      tick(); tick();
      rst = 1'b0;
      tick();
      send10(PT, K1, C1);
      drain(1'b0);

      expand(K3, 14, ks14);
      q14.push_back(C3);
      b14.in_data = PT;
      b14.in_valid = 1'b1;
      tick();
      b14.in_valid = 1'b0;
      n = 0;
      while (q14.size() != 0 && n < 100) begin tick(); n++; end
      if (q14.size() != 0) tmo("nr14");

      tick();
      chk("blk_count_end", b10.blk_count, PERF ? 128'(hs_cnt) : 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
